// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end for the mips32 pipeline.
// Owns the fetch PC, drives a synchronous instruction memory and presents
// instruction / PC+1 pairs to IF/ID. A one-entry skid buffer hides the
// one-cycle memory latency so hazard stalls never lose or repeat a word.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   stall      consumer does not accept the output this cycle
//   redirect   taken branch/jump resolved in ID (dominates stall)
//   redirectPc target word address, valid when redirect=1
//   imemAddr   address to synchronous instruction memory
//   imemData   memory data, valid the cycle after imemAddr
//   instOut    instruction to IF/ID (0 when valid=0)
//   pcOut      address of instOut plus 1 (0 when valid=0)
//   valid      instOut/pcOut carry a real instruction
module fetch_unit #(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirectPc,
  output logic [ADDR_W-1:0] imemAddr,
  input  logic [31:0]       imemData,
  output logic [31:0]       instOut,
  output logic [31:0]       pcOut,
  output logic              valid
);

  logic [31:0] fpc_q, fpc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic        skid_full_q, skid_full_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] skid_pc_q, skid_pc_d;

  // A redirect issues its target in the same cycle, bypassing fpc.
  assign imemAddr = redirect ? redirectPc[ADDR_W-1:0] : fpc_q[ADDR_W-1:0];

  // Output select: skid buffer has priority over the in-flight memory word
  // because a full skid always holds the older instruction.
  always_comb begin
    valid   = 1'b0;
    instOut = '0;
    pcOut   = '0;
    if (!redirect) begin
      if (skid_full_q) begin
        valid   = 1'b1;
        instOut = skid_inst_q;
        pcOut   = skid_pc_q + 32'd1;
      end else if (inflight_q) begin
        valid   = 1'b1;
        instOut = imemData;
        pcOut   = inflight_pc_q + 32'd1;
      end
    end
  end

  always_comb begin
    fpc_d         = fpc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    skid_full_d   = skid_full_q;
    skid_inst_d   = skid_inst_q;
    skid_pc_d     = skid_pc_q;
    if (redirect) begin
      skid_full_d   = 1'b0;
      inflight_d    = 1'b1;
      inflight_pc_d = redirectPc;
      fpc_d         = redirectPc + 32'd1;
    end else if (stall) begin
      // Memory data is only valid for one cycle; park it in the skid.
      if (inflight_q && !skid_full_q) begin
        skid_inst_d = imemData;
        skid_pc_d   = inflight_pc_q;
        skid_full_d = 1'b1;
        inflight_d  = 1'b0;
      end
    end else begin
      skid_full_d   = 1'b0;
      inflight_d    = 1'b1;
      inflight_pc_d = fpc_q;
      fpc_d         = fpc_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fpc_q         <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      skid_full_q   <= 1'b0;
      skid_inst_q   <= '0;
      skid_pc_q     <= '0;
    end else begin
      fpc_q         <= fpc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      skid_full_q   <= skid_full_d;
      skid_inst_q   <= skid_inst_d;
      skid_pc_q     <= skid_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit. Memory word at address a is
// 32'h1000_0000 | a. The stimulus pushes the instruction/PC+1 pairs it
// expects to be delivered; the monitor compares every valid output against
// the queue head and pops it when the consumer accepts it (stall=0).
// A second instance with RESET_PC=0xFE covers the reset-vector wrap.
module tb_fetch_unit;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, stall, redirect;
  logic [31:0] redirectPc;
  logic [7:0]  imemAddr;
  logic [31:0] imemData, instOut, pcOut;
  logic        valid;

  logic        stall2 = 1'b0, redirect2 = 1'b0;
  logic [31:0] redirectPc2 = '0;
  logic [7:0]  imemAddr2;
  logic [31:0] imemData2, instOut2, pcOut2;
  logic        valid2;

  logic bubble, en2, chk_rst, done;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t q2[$];

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(8), .RESET_PC(32'h0)) u_dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirectPc(redirectPc), .imemAddr(imemAddr), .imemData(imemData),
    .instOut(instOut), .pcOut(pcOut), .valid(valid));

  fetch_unit #(.ADDR_W(8), .RESET_PC(32'h000000FE)) u_dut2 (
    .clk(clk), .rst(rst), .stall(stall2), .redirect(redirect2),
    .redirectPc(redirectPc2), .imemAddr(imemAddr2), .imemData(imemData2),
    .instOut(instOut2), .pcOut(pcOut2), .valid(valid2));

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return 32'h1000_0000 | {24'h0, a};
  endfunction

  always @(posedge clk) begin
    imemData  <= mem_word(imemAddr);
    imemData2 <= mem_word(imemAddr2);
  end

  // Expected delivery of the word fetched from word address pc.
  function automatic exp_t mk(input logic [31:0] pc);
    exp_t e;
    e.inst = mem_word(pc[7:0]);
    e.pc   = pc + 32'd1;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      if (chk_rst) begin
        checks++;
        if (valid !== 1'b0 || instOut !== 32'h0 || pcOut !== 32'h0 || imemAddr !== 8'h00) begin
          errors++;
          $display("FAIL reset_outputs: got valid=%b inst=%h pc=%h addr=%h, expected 0 0 0 00",
                   valid, instOut, pcOut, imemAddr);
        end
        checks++;
        if (valid2 !== 1'b0 || imemAddr2 !== 8'hFE) begin
          errors++;
          $display("FAIL reset_outputs_fe: got valid=%b addr=%h, expected 0 fe", valid2, imemAddr2);
        end
      end
    end else if (done) begin
      checks++;
      if (q.size() != 0) begin
        errors++;
        $display("FAIL scoreboard_drain: got %0d undelivered, expected 0", q.size());
      end
    end else begin
      if (redirect) begin
        checks++;
        if (valid !== 1'b0 || imemAddr !== redirectPc[7:0]) begin
          errors++;
          $display("FAIL redirect_cycle: got valid=%b addr=%h, expected 0 %h",
                   valid, imemAddr, redirectPc[7:0]);
        end
        // The word that would have been on the output is discarded.
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL redirect_kill: got empty scoreboard, expected a killed entry");
        end else begin
          void'(q.pop_front());
        end
      end else if (bubble) begin
        checks++;
        if (valid !== 1'b0 || instOut !== 32'h0 || pcOut !== 32'h0) begin
          errors++;
          $display("FAIL bubble: got valid=%b inst=%h pc=%h, expected 0 0 0", valid, instOut, pcOut);
        end
      end else begin
        checks++;
        if (valid !== 1'b1) begin
          errors++;
          $display("FAIL unexpected_bubble: got valid=%b, expected 1", valid);
        end else if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got inst=%h pc=%h, expected nothing", instOut, pcOut);
        end else begin
          if (instOut !== q[0].inst || pcOut !== q[0].pc) begin
            errors++;
            $display("FAIL delivery: got inst=%h pc=%h, expected inst=%h pc=%h",
                     instOut, pcOut, q[0].inst, q[0].pc);
          end
          if (!stall) void'(q.pop_front());
        end
      end
      if (en2) begin
        checks++;
        if (q2.size() == 0) begin
          errors++;
          $display("FAIL wrap_queue: got empty scoreboard, expected an entry");
        end else begin
          if (valid2 !== 1'b1 || instOut2 !== q2[0].inst || pcOut2 !== q2[0].pc) begin
            errors++;
            $display("FAIL wrap_delivery: got valid=%b inst=%h pc=%h, expected 1 inst=%h pc=%h",
                     valid2, instOut2, pcOut2, q2[0].inst, q2[0].pc);
          end
          void'(q2.pop_front());
        end
      end
    end
  end

  task automatic cyc(input logic st, input logic rd, input logic [31:0] rpc, input logic bub);
    stall      = st;
    redirect   = rd;
    redirectPc = rpc;
    bubble     = bub;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirectPc = '0;
    bubble = 1'b0; en2 = 1'b0; chk_rst = 1'b0; done = 1'b0;
    @(posedge clk); #1;
    chk_rst = 1'b1;
    @(posedge clk); #1;
    chk_rst = 1'b0;
    rst = 1'b0;

    for (int unsigned i = 0; i < 6; i++) q.push_back(mk(i));
    q2.push_back(mk(32'hFE));
    q2.push_back(mk(32'hFF));
    q2.push_back(mk(32'h100));

    cyc(1'b0, 1'b0, '0, 1'b1);                       // address RESET_PC issued
    en2 = 1'b1;
    cyc(1'b0, 1'b0, '0, 1'b0);                       // mem[0]
    cyc(1'b0, 1'b0, '0, 1'b0);                       // mem[1]
    cyc(1'b1, 1'b0, '0, 1'b0);                       // mem[2] held, stall 1
    en2 = 1'b0;
    cyc(1'b1, 1'b0, '0, 1'b0);                       // stall 2 (skid)
    cyc(1'b1, 1'b0, '0, 1'b0);                       // stall 3 (skid)
    cyc(1'b0, 1'b0, '0, 1'b0);                       // release mem[2]
    cyc(1'b0, 1'b0, '0, 1'b0);                       // mem[3]
    cyc(1'b0, 1'b0, '0, 1'b0);                       // mem[4]

    for (int unsigned i = 32'h20; i < 32'h24; i++) q.push_back(mk(i));
    cyc(1'b0, 1'b1, 32'h20, 1'b0);                   // redirect kills mem[5]
    cyc(1'b0, 1'b0, '0, 1'b0);                       // mem[0x20]
    cyc(1'b0, 1'b0, '0, 1'b0);                       // mem[0x21]
    cyc(1'b0, 1'b0, '0, 1'b0);                       // mem[0x22]
    cyc(1'b1, 1'b0, '0, 1'b0);                       // mem[0x23] stalled
    cyc(1'b1, 1'b0, '0, 1'b0);                       // mem[0x23] from skid

    for (int unsigned i = 32'h40; i < 32'h44; i++) q.push_back(mk(i));
    cyc(1'b1, 1'b1, 32'h40, 1'b0);                   // redirect drops skid
    cyc(1'b0, 1'b0, '0, 1'b0);                       // mem[0x40]
    cyc(1'b0, 1'b0, '0, 1'b0);                       // mem[0x41]
    cyc(1'b0, 1'b0, '0, 1'b0);                       // mem[0x42]

    for (int unsigned i = 32'hFE; i < 32'h102; i++) q.push_back(mk(i));
    cyc(1'b0, 1'b1, 32'hFE, 1'b0);                   // redirect kills mem[0x43]
    cyc(1'b0, 1'b0, '0, 1'b0);                       // mem[0xFE], pc 0xFF
    cyc(1'b0, 1'b0, '0, 1'b0);                       // mem[0xFF], pc 0x100
    cyc(1'b0, 1'b0, '0, 1'b0);                       // mem[0x00], pc 0x101
    cyc(1'b1, 1'b0, '0, 1'b0);                       // mem[0x01] stalled
    cyc(1'b1, 1'b0, '0, 1'b0);                       // skid full
    rst = 1'b1;
    cyc(1'b1, 1'b0, '0, 1'b0);                       // reset mid-stall
    rst = 1'b0;

    q.push_back(mk(32'h0));
    q.push_back(mk(32'h1));
    cyc(1'b0, 1'b0, '0, 1'b1);                       // restart bubble
    cyc(1'b0, 1'b0, '0, 1'b0);                       // mem[0]
    cyc(1'b0, 1'b0, '0, 1'b0);                       // mem[1]

    done = 1'b1;
    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
